// File: rtl/plru_pkg_lv2.sv
// Shared definitions for the tree pseudo-LRU tracker: controller state
// encoding and the tree node-count helper.
package plru_pkg_lv2;

    // INIT clears every set, IDLE tracks accesses.
    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } plru_state_t;

    // A binary tree over ASSOC leaves has ASSOC-1 internal nodes.
    function automatic int plru_node_count(input int assoc);
        return assoc - 1;
    endfunction

endpackage

// File: rtl/plru_victim_lv2.sv
// Combinational tree walk: start at the root, follow each node bit
// (0 = left, 1 = right) down to a leaf. The bits taken on the way,
// MSB first, are the victim way number.
module plru_victim_lv2
    import plru_pkg_lv2::*;
#(
    parameter int ASSOC     = 8,
    parameter int ASSOC_WID = 3
) (
    input  logic [plru_node_count(ASSOC)-1:0] tree_bits,
    output logic [ASSOC_WID-1:0]              way
);

    localparam int NODES = plru_node_count(ASSOC);

    int   node;
    logic bit_val;

    // Walk one tree level per iteration; node selection uses constant
    // indices so the mux stays width-clean for any ASSOC.
    always_comb begin
        way     = '0;
        node    = 0;
        bit_val = 1'b0;
        for (int l = 0; l < ASSOC_WID; l++) begin
            bit_val = 1'b0;
            for (int n = 0; n < NODES; n++) begin
                if (n == node) bit_val = tree_bits[n];
            end
            way[ASSOC_WID-1-l] = bit_val;
            node = bit_val ? (2 * node + 2) : (2 * node + 1);
        end
    end

endmodule

// File: rtl/plru_tree_lv2.sv
// Per-set tree pseudo-LRU replacement tracker.
// After reset an INIT pass clears every set (one set per cycle); IDLE then
// accepts one access per cycle, repointing the path to the touched way away
// from it. The victim output is a combinational read of the current tree.
// Optional feature macro: PLRU_INVALID_PREF_EN adds way_valid and prefers
// the lowest-numbered invalid way over the tree victim.
module plru_tree_lv2
    import plru_pkg_lv2::*;
#(
    parameter int ASSOC       = 8,
    parameter int ASSOC_WID   = 3,
    parameter int NUM_OF_SETS = 256,
    parameter int INDEX_WID   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INDEX_WID-1:0] index_proc,
    input  logic                 access_valid,
    input  logic [ASSOC_WID-1:0] blk_accessed,
`ifdef PLRU_INVALID_PREF_EN
    input  logic [ASSOC-1:0]     way_valid,
`endif
    output logic [ASSOC_WID-1:0] lru_replacement_proc,
    output logic                 plru_ready
);

    localparam int                   NODES    = plru_node_count(ASSOC);
    localparam logic [INDEX_WID-1:0] LAST_SET = INDEX_WID'(NUM_OF_SETS - 1);

    plru_state_t          state;
    plru_state_t          state_nxt;
    logic [INDEX_WID-1:0] set_cnt;

    logic [NODES-1:0]     tree_mem [NUM_OF_SETS];
    logic [NODES-1:0]     rd_bits;
    logic [NODES-1:0]     upd_bits;
    logic                 wr_en;
    logic [INDEX_WID-1:0] wr_idx;
    logic [NODES-1:0]     wr_data;
    logic [ASSOC_WID-1:0] tree_victim;
    int                   node;
    logic                 dir;

    assign rd_bits = tree_mem[index_proc];

    // State register: reset always restarts the clearing pass.
    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    // Set counter: advances through INIT and parks on the last set.
    always_ff @(posedge clk) begin
        if (rst)                                      set_cnt <= '0;
        else if (state == INIT && set_cnt != LAST_SET) set_cnt <= set_cnt + 1'b1;
    end

    // Next state: leave INIT once the last set has been cleared.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (set_cnt == LAST_SET) state_nxt = IDLE;
            IDLE:    state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // Path update: every node on the way to blk_accessed points away from it.
    always_comb begin
        upd_bits = rd_bits;
        node     = 0;
        dir      = 1'b0;
        for (int l = 0; l < ASSOC_WID; l++) begin
            dir = blk_accessed[ASSOC_WID-1-l];
            for (int n = 0; n < NODES; n++) begin
                if (n == node) upd_bits[n] = ~dir;
            end
            node = dir ? (2 * node + 2) : (2 * node + 1);
        end
    end

    // Outputs and write port: INIT clears the counted set, IDLE writes back
    // the updated tree of an accepted access.
    always_comb begin
        plru_ready = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = index_proc;
        wr_data    = upd_bits;
        case (state)
            INIT: begin
                wr_en   = ~rst;
                wr_idx  = set_cnt;
                wr_data = '0;
            end
            IDLE: begin
                plru_ready = 1'b1;
                wr_en      = access_valid & ~rst;
            end
            default: ;
        endcase
    end

    // Tree storage: contents are defined by the INIT pass, not by reset.
    always_ff @(posedge clk) begin
        if (wr_en) tree_mem[wr_idx] <= wr_data;
    end

    plru_victim_lv2 #(
        .ASSOC     (ASSOC),
        .ASSOC_WID (ASSOC_WID)
    ) u_victim (
        .tree_bits (rd_bits),
        .way       (tree_victim)
    );

`ifdef PLRU_INVALID_PREF_EN
    logic                 any_invalid;
    logic [ASSOC_WID-1:0] invalid_way;

    // Victim select: lowest invalid way wins, else the tree victim.
    always_comb begin
        any_invalid = 1'b0;
        invalid_way = '0;
        for (int i = ASSOC - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                any_invalid = 1'b1;
                invalid_way = ASSOC_WID'(i);
            end
        end
        lru_replacement_proc = any_invalid ? invalid_way : tree_victim;
    end
`else
    assign lru_replacement_proc = tree_victim;
`endif

endmodule

// File: tb/tb_plru_tree_lv2.sv
// Self-checking bench for plru_tree_lv2 (default parameters).
// Optional feature macro: PLRU_INVALID_PREF_EN enables the invalid-way checks.
module tb_plru_tree_lv2;

    localparam int A  = 8;
    localparam int AW = 3;
    localparam int NS = 256;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] index_proc;
    logic          access_valid;
    logic [AW-1:0] blk_accessed;
    logic [AW-1:0] lru_replacement_proc;
    logic          plru_ready;
`ifdef PLRU_INVALID_PREF_EN
    logic [A-1:0]  way_valid;
`endif

    always #5 clk = ~clk;

    plru_tree_lv2 #(
        .ASSOC       (A),
        .ASSOC_WID   (AW),
        .NUM_OF_SETS (NS),
        .INDEX_WID   (IW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .index_proc           (index_proc),
        .access_valid         (access_valid),
        .blk_accessed         (blk_accessed),
`ifdef PLRU_INVALID_PREF_EN
        .way_valid            (way_valid),
`endif
        .lru_replacement_proc (lru_replacement_proc),
        .plru_ready           (plru_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference: heap-numbered node bits per set. Level l starts at node
    // 2^l - 1; the node offset within the level is the way-number prefix.
    int model [NS][A-1];

    typedef struct {
        int set_idx;
        int way;
        int exp_victim;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model_victim(input int s);
        int w;
        w = 0;
`ifdef PLRU_INVALID_PREF_EN
        for (int i = 0; i < A; i++) if (!way_valid[i]) return i;
`endif
        for (int l = 0; l < AW; l++) begin
            w = w * 2 + model[s][(1 << l) - 1 + w];
        end
        return w;
    endfunction

    task automatic model_touch(input int s, input int w);
        for (int l = 0; l < AW; l++) begin
            model[s][(1 << l) - 1 + (w >> (AW - l))] = (((w >> (AW - 1 - l)) & 1) == 0) ? 1 : 0;
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++)
            for (int n = 0; n < A - 1; n++) model[s][n] = 0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts low-ready cycles from the current negedge; bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!plru_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        access_valid = 1'b0;
    endtask

    // One access cycle: check the pre-update victim, then mirror the update.
    task automatic access(input int s, input int w, input bit v, input string tag);
        @(negedge clk);
        index_proc   = IW'(s);
        blk_accessed = AW'(w);
        access_valid = v;
        #1;
        chk(tag, lru_replacement_proc, model_victim(s));
        @(posedge clk);
        if (v) model_touch(s, w);
    endtask

    task automatic peek(input int s, input int exp, input string tag);
        @(negedge clk);
        access_valid = 1'b0;
        index_proc   = IW'(s);
        #1;
        chk(tag, lru_replacement_proc, exp);
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        index_proc   = IW'(3);
        blk_accessed = AW'(7);
        access_valid = 1'b1;
`ifdef PLRU_INVALID_PREF_EN
        way_valid    = '1;
`endif
        model_clear();

        vecs[0]  = '{5, 0, 4};
        vecs[1]  = '{5, 4, 2};
        vecs[2]  = '{9, 0, 4};
        vecs[3]  = '{9, 1, 4};
        vecs[4]  = '{9, 2, 4};
        vecs[5]  = '{9, 3, 4};
        vecs[6]  = '{9, 4, 0};
        vecs[7]  = '{9, 5, 0};
        vecs[8]  = '{9, 6, 0};
        vecs[9]  = '{9, 7, 0};
        vecs[10] = '{40, 7, 0};
        vecs[11] = '{40, 0, 4};

        // One-cycle reset, with an access held on set 3 throughout INIT.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ready", plru_ready, 0);
        wait_ready(n);
        chk("init_len", n, NS);
        chk("ready_after_init", plru_ready, 1);

        peek(0,   0, "init_set0");
        peek(128, 0, "init_set128");
        peek(255, 0, "init_set255");
        peek(3,   0, "init_access_ignored");

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            access(vecs[i].set_idx, vecs[i].way, 1'b1, "tbl_pre");
            peek(vecs[i].set_idx, vecs[i].exp_victim, $sformatf("tbl_%0d", i));
        end
        peek(10, 0, "set10_untouched");
        peek(9,  model_victim(9), "set9_model");

        // Back-to-back accesses on one set.
        access(20, 0, 1'b1, "b2b_0");
        access(20, 4, 1'b1, "b2b_1");
        peek(20, 2, "b2b_result");

        // Randomized traffic over a small set range to force collisions.
        for (int i = 0; i < 1500; i++) begin
            access($urandom_range(0, 15), $urandom_range(0, A - 1),
                   ($urandom_range(0, 3) != 0), "rand");
        end
        for (int s = 0; s < 16; s++) peek(s, model_victim(s), "rand_final");

`ifdef PLRU_INVALID_PREF_EN
        @(negedge clk);
        access_valid = 1'b0;
        index_proc   = IW'(5);
        way_valid    = 8'b1111_0111;
        #1;
        chk("inv_way3", lru_replacement_proc, 3);
        way_valid = 8'b0110_1111;
        #1;
        chk("inv_way4", lru_replacement_proc, 4);
        way_valid = '1;
        #1;
        chk("inv_all_valid", lru_replacement_proc, model_victim(5));
`endif

        // Reset again, then restart it 100 cycles into INIT.
        reset_pulse();
        repeat (100) @(negedge clk);
        chk("mid_init_ready", plru_ready, 0);
        reset_pulse();
        wait_ready(n);
        chk("reinit_len", n, NS);
        model_clear();
        for (int s = 0; s < NS; s++) peek(s, model_victim(s), "reinit_zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
